hawk_beacon_ctrl: RTL and testbench

HAWK_BEACON_CTRL -- requirements
Module: hawk_beacon_ctrl

---
 rtl/hawk_pkg.sv | 12 +
 rtl/hawk_phase_timer.sv | 27 ++
 rtl/hawk_beacon_ctrl.sv | 174 +++++++++++++++++
 tb/tb_hawk_beacon_ctrl.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/hawk_pkg.sv
// Shared state encoding for the hawk beacon controller.
package hawk_pkg;

    typedef logic [2:0] hawk_state_t;

    localparam hawk_state_t ST_DARK     = 3'd0;
    localparam hawk_state_t ST_FLASH_Y  = 3'd1;
    localparam hawk_state_t ST_STEADY_Y = 3'd2;
    localparam hawk_state_t ST_SOLID_R  = 3'd3;
    localparam hawk_state_t ST_WIGWAG   = 3'd4;

endpackage

// File: rtl/hawk_phase_timer.sv
// Loadable, tick-enabled phase down-counter; terminal marks the tick that ends a phase.
module hawk_phase_timer #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             tick,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic [CNT_W-1:0] count,
    output logic             terminal
);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (tick && count != '0) begin
            count <= count - 1'b1;
        end
    end

    assign terminal = tick && (count == CNT_W'(1));

endmodule

// File: rtl/hawk_beacon_ctrl.sv
// Pedestrian hybrid beacon controller: request latch, dark timer, phase sequencing and lamp decode.
module hawk_beacon_ctrl
    import hawk_pkg::*;
#(
    parameter int CNT_W      = 8,
    parameter int T_FY       = 6,
    parameter int T_SY       = 4,
    parameter int T_WALK     = 7,
    parameter int T_CLR      = 10,
    parameter int T_MIN_DARK = 20,
    parameter int FLASH_HALF = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             tick,
    input  logic             YP,
    input  logic             preempt,
    output logic             YL,
    output logic             RL_L,
    output logic             RL_R,
    output logic             W,
    output logic             DNW,
    output logic [CNT_W-1:0] countdown,
    output logic [2:0]       present_state,
    output logic             busy
);

    localparam int MAX_VAL = (1 << CNT_W) - 1;

    if (T_FY < 1 || T_FY > MAX_VAL || T_SY < 1 || T_SY > MAX_VAL ||
        T_WALK < 1 || T_WALK > MAX_VAL || T_CLR < 1 || T_CLR > MAX_VAL ||
        T_MIN_DARK < 1 || T_MIN_DARK > MAX_VAL ||
        FLASH_HALF < 1 || FLASH_HALF > MAX_VAL) begin : g_bad_params
        $error("hawk_beacon_ctrl: T_* and FLASH_HALF must lie in [1, 2^CNT_W-1]");
    end

    localparam logic [CNT_W-1:0] MIN_DARK_C = CNT_W'(T_MIN_DARK);
    localparam logic [CNT_W-1:0] HALF_C     = CNT_W'(FLASH_HALF);
    localparam logic [CNT_W-1:0] ONE_C      = CNT_W'(1);

    hawk_state_t      state, state_next;
    logic             req_pending;
    logic [CNT_W-1:0] dark_timer;
    logic [CNT_W-1:0] flash_cnt;
    logic             flash_on;
    logic [CNT_W-1:0] phase_cnt;
    logic [CNT_W-1:0] load_val;
    logic             phase_load;
    logic             phase_done;
    logic             flashing_next;
    logic             entering_flash;

    // NOTE: every combinational output gets a default first so no latch is inferred.
    always_comb begin
        state_next = state;
        case (state)
            ST_DARK:
                if (req_pending && dark_timer == MIN_DARK_C && !preempt) state_next = ST_FLASH_Y;
            ST_FLASH_Y:
                if (preempt)         state_next = ST_DARK;
                else if (phase_done) state_next = ST_STEADY_Y;
            ST_STEADY_Y: if (phase_done) state_next = ST_SOLID_R;
            ST_SOLID_R:  if (phase_done) state_next = ST_WIGWAG;
            ST_WIGWAG:   if (phase_done) state_next = ST_DARK;
            default:     state_next = ST_DARK;
        endcase
    end

    always_comb begin
        load_val = '0;
        case (state_next)
            ST_FLASH_Y:  load_val = CNT_W'(T_FY);
            ST_STEADY_Y: load_val = CNT_W'(T_SY);
            ST_SOLID_R:  load_val = CNT_W'(T_WALK);
            ST_WIGWAG:   load_val = CNT_W'(T_CLR);
            default:     load_val = '0;
        endcase
    end

    // A phase change reloads the counter, which outranks a coincident tick decrement.
    assign phase_load = (state_next != state);

    hawk_phase_timer #(.CNT_W(CNT_W)) u_phase_timer (
        .clk      (clk),
        .reset    (reset),
        .tick     (tick),
        .load     (phase_load),
        .load_val (load_val),
        .count    (phase_cnt),
        .terminal (phase_done)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= ST_DARK;
        else       state <= state_next;
    end

    // Service start consumes the request; a preempt abort from FLASH_Y re-arms it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            req_pending <= 1'b0;
        end else if (state == ST_DARK && state_next == ST_FLASH_Y) begin
            req_pending <= 1'b0;
        end else if (state == ST_FLASH_Y && state_next == ST_DARK) begin
            req_pending <= 1'b1;
        end else if (YP) begin
            req_pending <= 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dark_timer <= MIN_DARK_C;
        end else if (state != ST_DARK && state_next == ST_DARK) begin
            dark_timer <= '0;
        end else if (state == ST_DARK && tick && dark_timer != MIN_DARK_C) begin
            dark_timer <= dark_timer + 1'b1;
        end
    end

    assign flashing_next  = (state_next == ST_FLASH_Y) || (state_next == ST_WIGWAG);
    assign entering_flash = flashing_next && phase_load;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            flash_on  <= 1'b0;
            flash_cnt <= '0;
        end else if (entering_flash) begin
            flash_on  <= 1'b1;
            flash_cnt <= HALF_C;
        end else if (!flashing_next) begin
            flash_on  <= 1'b0;
            flash_cnt <= '0;
        end else if (tick) begin
            if (flash_cnt == ONE_C) begin
                flash_on  <= ~flash_on;
                flash_cnt <= HALF_C;
            end else begin
                flash_cnt <= flash_cnt - 1'b1;
            end
        end
    end

    // Lamps depend only on registered state, so inputs never reach outputs combinationally.
    always_comb begin
        YL        = 1'b0;
        RL_L      = 1'b0;
        RL_R      = 1'b0;
        W         = 1'b0;
        DNW       = 1'b1;
        countdown = '0;
        case (state)
            ST_FLASH_Y:  YL = flash_on;
            ST_STEADY_Y: YL = 1'b1;
            ST_SOLID_R: begin
                RL_L = 1'b1;
                RL_R = 1'b1;
                W    = 1'b1;
                DNW  = 1'b0;
            end
            ST_WIGWAG: begin
                RL_L      = flash_on;
                RL_R      = ~flash_on;
                DNW       = flash_on;
                countdown = phase_cnt;
            end
            default: ;
        endcase
    end

    assign present_state = state;
    assign busy          = (state != ST_DARK);

endmodule

// File: tb/tb_hawk_beacon_ctrl.sv
// Self-checking bench: default build plus a T_FY=1/FLASH_HALF=2 build against a timeline model.
module tb_hawk_beacon_ctrl;
    import hawk_pkg::*;

    localparam int MIN_DARK = 20;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic tick = 1'b0;
    logic YP = 1'b0;
    logic preempt = 1'b0;

    logic       a_yl, a_rll, a_rlr, a_w, a_dnw, a_busy;
    logic [7:0] a_cd;
    logic [2:0] a_state;
    logic       b_yl, b_rll, b_rlr, b_w, b_dnw, b_busy;
    logic [7:0] b_cd;
    logic [2:0] b_state;
    logic [31:0] a_vec, b_vec;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    hawk_beacon_ctrl u_dut_a (
        .clk(clk), .reset(reset), .tick(tick), .YP(YP), .preempt(preempt),
        .YL(a_yl), .RL_L(a_rll), .RL_R(a_rlr), .W(a_w), .DNW(a_dnw),
        .countdown(a_cd), .present_state(a_state), .busy(a_busy)
    );

    hawk_beacon_ctrl #(.T_FY(1), .FLASH_HALF(2)) u_dut_b (
        .clk(clk), .reset(reset), .tick(tick), .YP(YP), .preempt(preempt),
        .YL(b_yl), .RL_L(b_rll), .RL_R(b_rlr), .W(b_w), .DNW(b_dnw),
        .countdown(b_cd), .present_state(b_state), .busy(b_busy)
    );

    assign a_vec = {15'd0, a_yl, a_rll, a_rlr, a_w, a_dnw, a_busy, a_state, a_cd};
    assign b_vec = {15'd0, b_yl, b_rll, b_rlr, b_w, b_dnw, b_busy, b_state, b_cd};

    // Model: phase index 0..4, ticks elapsed in the phase, request flag, dark ticks seen.
    typedef struct {
        int phase;
        int elapsed;
        bit req;
        int dark;
    } mdl_t;

    mdl_t m [2];
    int dur [2][5] = '{'{0, 6, 4, 7, 10}, '{0, 1, 4, 7, 10}};
    int fh [2] = '{1, 2};

    function automatic mdl_t mdl_reset();
        mdl_t s;
        s.phase = 0;
        s.elapsed = 0;
        s.req = 1'b0;
        s.dark = MIN_DARK;
        return s;
    endfunction

    function automatic mdl_t mdl_next(mdl_t s, int k, bit yp, bit pre, bit tk);
        mdl_t n;
        int np;
        bit go;
        bit abort;
        n = s;
        np = s.phase;
        go = (s.phase == 0) && s.req && (s.dark == MIN_DARK) && !pre;
        abort = 1'b0;
        if (go) np = 1;
        else if (s.phase == 1 && pre) begin
            abort = 1'b1;
            np = 0;
        end else if (s.phase != 0 && tk && s.elapsed + 1 == dur[k][s.phase]) np = (s.phase + 1) % 5;
        n.phase = np;
        n.req = go ? 1'b0 : (abort ? 1'b1 : (yp ? 1'b1 : s.req));
        n.elapsed = (np != s.phase) ? 0 : (tk ? s.elapsed + 1 : s.elapsed);
        if (np == 0 && s.phase != 0) n.dark = 0;
        else if (s.phase == 0 && tk && s.dark < MIN_DARK) n.dark = s.dark + 1;
        return n;
    endfunction

    function automatic logic [31:0] mdl_out(mdl_t s, int k);
        bit f;
        logic yl, rll, rlr, w, dnw;
        int cd;
        f = ((s.elapsed / fh[k]) % 2) == 0;
        yl = 1'b0; rll = 1'b0; rlr = 1'b0; w = 1'b0; dnw = 1'b1; cd = 0;
        case (s.phase)
            1: yl = f;
            2: yl = 1'b1;
            3: begin rll = 1'b1; rlr = 1'b1; w = 1'b1; dnw = 1'b0; end
            4: begin rll = f; rlr = !f; dnw = f; cd = dur[k][4] - s.elapsed; end
            default: ;
        endcase
        return {15'd0, yl, rll, rlr, w, dnw, (s.phase != 0), 3'(s.phase), 8'(cd)};
    endfunction

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(bit yp, bit pre, bit tk);
        @(negedge clk);
        YP = yp;
        preempt = pre;
        tick = tk;
        @(posedge clk);
        for (int k = 0; k < 2; k++) m[k] = mdl_next(m[k], k, yp, pre, tk);
        #1;
        check("A_outputs", a_vec, mdl_out(m[0], 0));
        check("B_outputs", b_vec, mdl_out(m[1], 1));
    endtask

    task automatic tick_unit(bit yp, bit pre);
        step(yp, pre, 1'b1);
        step(1'b0, pre, 1'b0);
        step(1'b0, pre, 1'b0);
    endtask

    task automatic ticks_until(logic [2:0] target, bit pre, output int n);
        n = 0;
        while (a_state != target && n < 200) begin
            tick_unit(1'b0, pre);
            n++;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        YP = 1'b0;
        preempt = 1'b0;
        tick = 1'b0;
        #1;
        for (int k = 0; k < 2; k++) m[k] = mdl_reset();
        check("reset_A", a_vec, mdl_out(m[0], 0));
        check("reset_B", b_vec, mdl_out(m[1], 1));
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        int cyc;

        do_reset();
        check("reset_dnw", 32'(a_dnw), 32'd1);
        check("reset_state", 32'(a_state), 32'(ST_DARK));

        // One-cycle push: request latched, then FLASH_Y on the following edge.
        step(1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        check("yp_to_flash_A", 32'(a_state), 32'(ST_FLASH_Y));
        check("yp_to_flash_B", 32'(b_state), 32'(ST_FLASH_Y));
        check("fy_entry_yl_B", 32'(b_yl), 32'd1);

        tick_unit(1'b0, 1'b0);
        check("fy_one_tick_B", 32'(b_state), 32'(ST_STEADY_Y));
        check("fy_toggle_A", 32'(a_yl), 32'd0);

        ticks_until(ST_STEADY_Y, 1'b0, n);
        check("fy_ticks", 32'(n + 1), 32'd6);
        ticks_until(ST_SOLID_R, 1'b0, n);
        check("sy_ticks", 32'(n), 32'd4);
        ticks_until(ST_WIGWAG, 1'b0, n);
        check("walk_ticks", 32'(n), 32'd7);
        check("cd_entry", 32'(a_cd), 32'd10);
        ticks_until(ST_DARK, 1'b0, n);
        check("clr_ticks", 32'(n), 32'd10);
        check("cd_dark", 32'(a_cd), 32'd0);

        // Fresh DARK: request waits out the full minimum dark time.
        step(1'b1, 1'b0, 1'b0);
        ticks_until(ST_FLASH_Y, 1'b0, n);
        check("min_dark_1", 32'(n), 32'd20);
        ticks_until(ST_SOLID_R, 1'b0, n);
        check("fy_sy_ticks", 32'(n), 32'd10);

        // Push and preempt during SOLID_R: timing unchanged, request queued.
        step(1'b1, 1'b1, 1'b0);
        ticks_until(ST_WIGWAG, 1'b1, n);
        check("walk_preempt", 32'(n), 32'd7);
        ticks_until(ST_DARK, 1'b0, n);
        check("clr_after_pre", 32'(n), 32'd10);
        ticks_until(ST_FLASH_Y, 1'b0, n);
        check("min_dark_2", 32'(n), 32'd20);

        // Preempt on the third FLASH_Y tick aborts to DARK.
        tick_unit(1'b0, 1'b0);
        tick_unit(1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b1);
        check("preempt_state", 32'(a_state), 32'(ST_DARK));
        check("preempt_busy", 32'(a_busy), 32'd0);
        for (int i = 0; i < 25; i++) tick_unit(1'b0, 1'b1);
        check("held_dark", 32'(a_state), 32'(ST_DARK));
        step(1'b0, 1'b0, 1'b0);
        check("release_flash", 32'(a_state), 32'(ST_FLASH_Y));

        for (int i = 0; i < 600; i++)
            step($urandom_range(0, 19) == 0, $urandom_range(0, 29) == 0, $urandom_range(0, 2) == 0);

        // Reset in the middle of clearance.
        step(1'b1, 1'b0, 1'b0);
        cyc = 0;
        while (!(a_state == ST_WIGWAG && a_cd == 8'd5) && cyc < 3000) begin
            step($urandom_range(0, 49) == 0, 1'b0, $urandom_range(0, 2) == 0);
            cyc++;
        end
        check("reach_cd5", {21'd0, a_state, a_cd}, {21'd0, ST_WIGWAG, 8'd5});
        do_reset();
        check("abort_busy", 32'(a_busy), 32'd0);
        check("abort_cd", 32'(a_cd), 32'd0);
        step(1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        check("post_reset_flash", 32'(a_state), 32'(ST_FLASH_Y));
        for (int i = 0; i < 4; i++) tick_unit(1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
